// File: rtl/ch3_wt_disp_sched_pkg.sv
// Shared types and constants for the HH:MM:SS display scheduler.
// Optional feature macro: CH3_WT_BLINK_EN (set-field blinking).
package ch3_wt_pkg;

  typedef enum logic [2:0] {
    CONV_H,
    CONV_M,
    CONV_S,
    COMMIT,
    SCAN
  } state_t;

  localparam int unsigned NUM_DIGITS = 6;

  // Digit positions on the display, left to right
  localparam int unsigned DIG_HT = 0;
  localparam int unsigned DIG_HO = 1;
  localparam int unsigned DIG_MT = 2;
  localparam int unsigned DIG_MO = 3;
  localparam int unsigned DIG_ST = 4;
  localparam int unsigned DIG_SO = 5;

  // SET_FIELD codes
  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HOUR = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

  // Digit strobes belonging to a SET_FIELD selection
  function automatic logic [5:0] field_digits(input logic [1:0] fld);
    logic [5:0] m;
    case (fld)
      FLD_HOUR: m = 6'b000011;
      FLD_MIN:  m = 6'b001100;
      FLD_SEC:  m = 6'b110000;
      default:  m = 6'b000000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ch3_wt_disp_sched_if.sv
// Time/alarm inputs and digit-driver outputs of the display scheduler.
// Optional feature macro: CH3_WT_BLINK_EN adds SET_FIELD.
interface ch3_wt_disp_sched_if;
  logic [6:0] HOUR;
  logic [6:0] MIN;
  logic [6:0] SEC;
  logic [6:0] AL_HOUR;
  logic [6:0] AL_MIN;
  logic       ALARM_VIEW;
`ifdef CH3_WT_BLINK_EN
  logic [1:0] SET_FIELD;
`endif
  logic [5:0] DIGIT_EN;
  logic [3:0] DIGIT_BCD;
  logic       FRAME_DONE;

  modport master (
    output HOUR, MIN, SEC, AL_HOUR, AL_MIN, ALARM_VIEW,
`ifdef CH3_WT_BLINK_EN
    output SET_FIELD,
`endif
    input  DIGIT_EN, DIGIT_BCD, FRAME_DONE
  );

  modport slave (
    input  HOUR, MIN, SEC, AL_HOUR, AL_MIN, ALARM_VIEW,
`ifdef CH3_WT_BLINK_EN
    input  SET_FIELD,
`endif
    output DIGIT_EN, DIGIT_BCD, FRAME_DONE
  );
endinterface

// File: rtl/ch3_wt_disp_sched_sep.sv
// Two-digit separator: 0..59 -> tens/ones BCD; anything above 59 gives 0,0.
module CH3_WT_SEP (
  input  logic [6:0] NUMBER,
  output logic [3:0] SEP_A,
  output logic [3:0] SEP_B
);

  // Combinational split into tens (SEP_A) and ones (SEP_B)
  always_comb begin
    SEP_A = '0;
    SEP_B = '0;
    if (NUMBER <= 7'd59) begin
      SEP_A = 4'(NUMBER / 7'd10);
      SEP_B = 4'(NUMBER % 7'd10);
    end
  end

endmodule

// File: rtl/ch3_wt_disp_sched.sv
// Time-multiplexed 6-digit HH:MM:SS display scheduler.
// Converts hour/min/sec through one shared separator into a shadow buffer,
// commits it atomically, then scans the digits SCAN_DIV cycles each.
// Optional feature macro: CH3_WT_BLINK_EN (blank the field being set).
module ch3_wt_disp_sched
  import ch3_wt_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
`ifdef CH3_WT_BLINK_EN
  , parameter int unsigned BLINK_FRAMES = 64
`endif
) (
  input logic                 CLK,
  input logic                 RESET,
  ch3_wt_disp_sched_if.slave  bus
);

  localparam int unsigned     CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  state_t           state;
  logic             view_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic [3:0]       shadow [NUM_DIGITS];
  logic [3:0]       disp   [NUM_DIGITS];
  logic [6:0]       sep_in;
  logic [3:0]       sep_a;
  logic [3:0]       sep_b;
  logic [5:0]       en_mask;
  logic [5:0]       en_q;
  logic [3:0]       bcd_q;
  logic             fd_q;
  logic             frame_end;

  assign bus.DIGIT_EN   = en_q;
  assign bus.DIGIT_BCD  = bcd_q;
  assign bus.FRAME_DONE = fd_q;

  // Last cycle of the digit-5 slot
  always_comb begin
    idx_nxt   = idx + 3'd1;
    frame_end = (state == SCAN) && (cnt == CNT_LAST) && (idx == 3'(DIG_SO));
  end

  // Separator input selected by the conversion step
  always_comb begin
    case (state)
      CONV_H:  sep_in = bus.ALARM_VIEW ? bus.AL_HOUR : bus.HOUR;
      CONV_M:  sep_in = view_q ? bus.AL_MIN : bus.MIN;
      CONV_S:  sep_in = view_q ? 7'd0 : bus.SEC;
      default: sep_in = '0;
    endcase
  end

  CH3_WT_SEP u_sep (
    .NUMBER (sep_in),
    .SEP_A  (sep_a),
    .SEP_B  (sep_b)
  );

`ifdef CH3_WT_BLINK_EN
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FCNT_W-1:0] fcnt;
  logic              blink_ph;

  // Blink phase flips after every BLINK_FRAMES completed frames
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fcnt     <= '0;
      blink_ph <= 1'b0;
    end else if (frame_end) begin
      if (fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
        fcnt     <= '0;
        blink_ph <= ~blink_ph;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Strobes of the field being set are suppressed in the blank phase
  always_comb en_mask = blink_ph ? ~field_digits(bus.SET_FIELD) : '1;
`else
  // No field blanking in this build
  always_comb en_mask = '1;
`endif

  // Conversion/commit/scan sequencer with registered digit outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= CONV_H;
      view_q <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
      en_q   <= '0;
      bcd_q  <= '0;
      fd_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        disp[i]   <= '0;
      end
    end else begin
      fd_q <= 1'b0;
      case (state)
        CONV_H: begin
          view_q         <= bus.ALARM_VIEW;
          shadow[DIG_HT] <= sep_a;
          shadow[DIG_HO] <= sep_b;
          state          <= CONV_M;
        end
        CONV_M: begin
          shadow[DIG_MT] <= sep_a;
          shadow[DIG_MO] <= sep_b;
          state          <= CONV_S;
        end
        CONV_S: begin
          shadow[DIG_ST] <= sep_a;
          shadow[DIG_SO] <= sep_b;
          state          <= COMMIT;
        end
        COMMIT: begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) disp[i] <= shadow[i];
          idx   <= '0;
          cnt   <= '0;
          // disp loads on this same edge, so digit 0 is taken from shadow
          en_q  <= 6'b000001 & en_mask;
          bcd_q <= shadow[DIG_HT];
          state <= SCAN;
        end
        SCAN: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == 3'(DIG_SO)) begin
              idx   <= '0;
              en_q  <= '0;
              bcd_q <= '0;
              fd_q  <= 1'b1;
              state <= CONV_H;
            end else begin
              idx   <= idx_nxt;
              en_q  <= (6'b000001 << idx_nxt) & en_mask;
              bcd_q <= disp[idx_nxt];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= CONV_H;
      endcase
    end
  end

endmodule

// File: tb/tb_ch3_wt_disp_sched.sv
// Self-checking bench for ch3_wt_disp_sched: frame scoreboard against a
// timeline model, plus a SCAN_DIV=1 instance. Honours CH3_WT_BLINK_EN.
module tb_ch3_wt_disp_sched;

  localparam int unsigned SD  = 4;
  localparam int unsigned P   = 6 * SD + 4;
  localparam int unsigned P1  = 10;
`ifdef CH3_WT_BLINK_EN
  localparam int unsigned BF  = 2;
`endif

  logic CLK    = 1'b0;
  logic RESET  = 1'b1;
  logic RESET1 = 1'b1;

  ch3_wt_disp_sched_if u_if  ();
  ch3_wt_disp_sched_if u_if1 ();

  ch3_wt_disp_sched #(
    .SCAN_DIV (SD)
`ifdef CH3_WT_BLINK_EN
    , .BLINK_FRAMES (BF)
`endif
  ) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (u_if)
  );

  ch3_wt_disp_sched #(
    .SCAN_DIV (1)
  ) u_dut1 (
    .CLK   (CLK),
    .RESET (RESET1),
    .bus   (u_if1)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Expected frames, digit d in bits [4d +: 4]
  logic [23:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_frame(input int unsigned h, input int unsigned m,
                                              input int unsigned s, input int unsigned ah,
                                              input int unsigned am, input bit v);
    int unsigned f [3];
    logic [23:0] r;
    r    = '0;
    f[0] = v ? ah : h;
    f[1] = v ? am : m;
    f[2] = v ? 0  : s;
    for (int i = 0; i < 3; i++) begin
      if (f[i] <= 59) begin
        r[8*i +: 4]     = 4'(f[i] / 10);
        r[8*i + 4 +: 4] = 4'(f[i] % 10);
      end
    end
    return r;
  endfunction

  task automatic drive(input int unsigned h, input int unsigned m, input int unsigned s,
                       input int unsigned ah, input int unsigned am, input bit v);
    u_if.HOUR       = 7'(h);
    u_if.MIN        = 7'(m);
    u_if.SEC        = 7'(s);
    u_if.AL_HOUR    = 7'(ah);
    u_if.AL_MIN     = 7'(am);
    u_if.ALARM_VIEW = v;
    exp_q.push_back(model_frame(h, m, s, ah, am, v));
  endtask

  // Wait (bounded) until the display is lit / blank
  task automatic wait_lit(input bit want);
    int unsigned n;
    n = 0;
    while (((u_if.DIGIT_EN != 0) || (want == 1'b0 && u_if.FRAME_DONE)) != want && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    check("wait_lit_bound", 32'((u_if.DIGIT_EN != 0) == want), 32'd1);
  endtask

  task automatic next_frame(input int unsigned k, input int unsigned h, input int unsigned m,
                            input int unsigned s, input int unsigned ah, input int unsigned am,
                            input bit v);
    wait_lit(1'b0);
    wait_lit(1'b1);
    repeat (k) begin @(posedge CLK); #1; end
    drive(h, m, s, ah, am, v);
  endtask

  // ---------------- monitor for the SCAN_DIV=SD instance ----------------
  logic        rst_smp  = 1'b1;
  logic        rst1_smp = 1'b1;
  int unsigned t  = 0;
  int unsigned t1 = 0;
  logic [23:0] cur = '0;

  always @(posedge CLK) begin
    rst_smp  <= RESET;
    rst1_smp <= RESET1;
  end

  always @(negedge CLK) begin
    int unsigned p;
    int unsigned d;
    logic [5:0]  exp_en;
    if (rst_smp) begin
      check("reset_digit_en", 32'(u_if.DIGIT_EN), 32'd0);
      check("reset_digit_bcd", 32'(u_if.DIGIT_BCD), 32'd0);
      check("reset_frame_done", 32'(u_if.FRAME_DONE), 32'd0);
      t = 1;
    end else begin
      p = t % P;
      d = 0;
      if (p == 4) begin
        check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
      end
      exp_en = '0;
      if (p >= 4) begin
        d      = (p - 4) / SD;
        exp_en = 6'b000001 << d;
`ifdef CH3_WT_BLINK_EN
        if (((t / P) / BF) % 2 == 1) exp_en = exp_en & ~6'b001100;
`endif
      end
      check("frame_done", 32'(u_if.FRAME_DONE), 32'(p == 0));
      check("digit_en", 32'(u_if.DIGIT_EN), 32'(exp_en));
      if (p >= 4) check("digit_bcd", 32'(u_if.DIGIT_BCD), 32'(cur[4*d +: 4]));
      t++;
    end
  end

  // ---------------- monitor for the SCAN_DIV=1 instance ----------------
  // Fixed input 23:59:60 -> 2,3,5,9,0,0
  always @(negedge CLK) begin
    int unsigned p;
    logic [23:0] f1;
    f1 = {4'd0, 4'd0, 4'd9, 4'd5, 4'd3, 4'd2};
    if (rst1_smp) begin
      check("sd1_reset_en", 32'(u_if1.DIGIT_EN), 32'd0);
      t1 = 1;
    end else begin
      p = t1 % P1;
      check("sd1_frame_done", 32'(u_if1.FRAME_DONE), 32'(p == 0));
      check("sd1_digit_en", 32'(u_if1.DIGIT_EN), (p >= 4) ? 32'(6'b000001 << (p - 4)) : 32'd0);
      if (p >= 4) check("sd1_digit_bcd", 32'(u_if1.DIGIT_BCD), 32'(f1[4*(p-4) +: 4]));
      t1++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned n;
    u_if1.HOUR       = 7'd23;
    u_if1.MIN        = 7'd59;
    u_if1.SEC        = 7'd60;
    u_if1.AL_HOUR    = 7'd0;
    u_if1.AL_MIN     = 7'd0;
    u_if1.ALARM_VIEW = 1'b0;
`ifdef CH3_WT_BLINK_EN
    u_if.SET_FIELD   = 2'd2;
    u_if1.SET_FIELD  = 2'd0;
`endif
    drive(13, 45, 7, 0, 0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    RESET  = 1'b0;
    RESET1 = 1'b0;

    // MIN 45 -> 46 during the digit-1 slot of frame 1
    next_frame(SD, 13, 46, 7, 6, 30, 1'b0);
    // alarm view selected for frame 3
    next_frame(2, 13, 46, 7, 6, 30, 1'b1);
    // view dropped mid frame 3, seconds out of range for frame 4
    next_frame(3 * SD, 9, 5, 60, 6, 30, 1'b0);

    for (int i = 0; i < 16; i++)
      next_frame($urandom_range(0, 6 * SD - 1), $urandom_range(0, 30), $urandom_range(0, 70),
                 $urandom_range(0, 70), $urandom_range(0, 30), $urandom_range(0, 70),
                 1'($urandom_range(0, 1)));

    // reset during the digit-3 slot
    wait_lit(1'b0);
    wait_lit(1'b1);
    repeat (3 * SD + 1) begin @(posedge CLK); #1; end
    RESET = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    drive(21, 8, 59, 0, 0, 1'b0);
    RESET = 1'b0;

    for (int i = 0; i < 4; i++)
      next_frame($urandom_range(0, 6 * SD - 1), $urandom_range(0, 30), $urandom_range(0, 70),
                 $urandom_range(0, 70), $urandom_range(0, 30), $urandom_range(0, 70),
                 1'($urandom_range(0, 1)));

    // let the last expected frame be displayed completely
    wait_lit(1'b0);
    wait_lit(1'b1);
    n = 0;
    while (!u_if.FRAME_DONE && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    check("final_frame_done_bound", 32'(u_if.FRAME_DONE), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
